ps2_rx_history: RTL and testbench
=================================

# ps2_rx_history

Parametrised PS/2 keyboard receiver for the CLOCK_50 domain. It synchronises the raw PS2_CLK/PS2_DAT pins and decodes 11-bit frames with odd-parity, stop-bit and inter-bit timeout checking. It folds E0/F0 prefixes into flags and keeps a configurable-depth history of make codes. It sits between the board PS/2 pins and the hex/speed display logic, and replaces fixed three-key capture.

## Interface
Parameters:
- HIST_DEPTH, 3: number of make codes retained; ≥1.
- SYNC_STAGES, 2: flip-flop stages on ps2_clk and ps2_dat; ≥2.
- TIMEOUT_CYCLES, 50000: maximum CLOCK_50 cycles between falling ps2_clk edges inside a frame; ≥16.

Ports:
- CLOCK_50  in  1  system clock; all logic on posedge.
- resetn  in  1  synchronous, active-low reset.
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous.
- ps2_dat  in  1  raw PS/2 data pin, asynchronous.
- clear_hist  in  1  synchronous clear of history and hist_count.
- code_valid  out  1  one-cycle pulse when a complete non-prefix code is decoded.
- code  out  8  last decoded code; held until the next code_valid.
- code_ext  out  1  E0 prefix preceded code; held with code.
- code_break  out  1  F0 prefix preceded code; held with code.
- history  out  8*HIST_DEPTH  make codes; newest in [7:0], oldest in the top byte.
- hist_count  out  clog2(HIST_DEPTH+1)  valid entries; saturates at HIST_DEPTH.
- parity_err  out  1  one-cycle pulse on a parity failure.
- frame_err  out  1  one-cycle pulse on a bad stop bit or timeout.
- busy  out  1  high while a frame is in progress (not IDLE).

## Operation
- Both pins pass through SYNC_STAGES flip-flops. One further register detects falls: fall = prev_clk & ~sync_clk. All bit sampling uses sync_dat in the fall cycle.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on a fall with sync_dat=0, go to DATA with bit_cnt=0. A fall with sync_dat=1 is ignored.
  - DATA: each fall shifts sync_dat into shreg[bit_cnt] (LSB first). After bit 7, go to PARITY.
  - PARITY: a fall captures the parity bit and moves to STOP.
  - STOP: a fall returns to IDLE. If the stop bit is 0, pulse frame_err. Otherwise, if the parity bit ≠ ~^shreg, pulse parity_err. Otherwise the byte is accepted. Stop-bit failure takes priority over parity failure.
- Timeout counter: clears on every fall and increments in non-IDLE states. At TIMEOUT_CYCLES-1 it forces IDLE, pulses frame_err and drops the partial byte.
- Accepted byte handling:
  - 0xE0 sets ext_pend.
  - 0xF0 sets brk_pend.
  - Any other byte loads code, code_ext=ext_pend and code_break=brk_pend, pulses code_valid, then clears both pend flags.
- Any parity_err or frame_err clears ext_pend and brk_pend.
- History push occurs on code_valid with code_break=0 only. Entries shift up one byte, the new code goes into [7:0], the oldest entry is discarded when full, and hist_count increments to saturation.
- clear_hist zeroes history and hist_count. If clear_hist and a push occur in the same cycle, the result is history={0…,code}, hist_count=1.
- Reset values: code=0, code_ext=0, code_break=0, history=0, hist_count=0, all pulses 0, busy=0, FSM=IDLE, pend flags 0, timeout=0, synchroniser flops=1 (bus idle).

## Timing
- Pin-to-fall detection: SYNC_STAGES+1 CLOCK_50 cycles.
- code_valid, history update and the error pulses all register one cycle after the STOP-state fall cycle (cycle F+1). code/flags change at the same edge.
- busy rises on the cycle after the start-bit fall and falls when the FSM returns to IDLE.
- resetn low mid-frame aborts the frame with no pulses. The first frame after reset decodes normally.
- Back-to-back frames: a start fall immediately after the STOP fall is accepted.

## Test plan
- Send 0x1C (parity 0, stop 1) at a 12.5 kHz clock. Required: one code_valid, code=0x1C, ext=0, break=0, history[7:0]=0x1C, hist_count=1.
- Send F0 (parity 1) then 1C. Required: a single code_valid with code=0x1C and break=1; history and hist_count unchanged.
- Send E0 (parity 0) then 75 (parity 0). Required: code=0x75, ext=1, break=0, and 0x75 pushed.
- Send 0x1C with parity 1. Required: parity_err pulse, no code_valid. Send a 0x1C frame with stop 0. Required: frame_err only.
- With HIST_DEPTH=3, send 1C,32,21,23. Required: history={0x32,0x21,0x23} (newest low), hist_count=3. Then assert clear_hist together with code 0x24 arriving. Required: history[7:0]=0x24, hist_count=1.
- Send a start bit plus 4 bits, then idle for ≥TIMEOUT_CYCLES. Required: frame_err at the timeout, busy=0. A following 0x1C frame must decode correctly. Pull resetn low mid-frame: no pulses, all outputs return to reset values.

Source files
------------

// File: rtl/ps2_rx_history_if.sv
// PS/2 receiver bus: raw pins and clear in, decoded code/history/status out.
interface ps2_rx_history_if #(
  parameter int HIST_DEPTH = 3
);
  logic                                ps2_clk;
  logic                                ps2_dat;
  logic                                clear_hist;
  logic                                code_valid;
  logic [7:0]                          code;
  logic                                code_ext;
  logic                                code_break;
  logic [8*HIST_DEPTH-1:0]             history;
  logic [$clog2(HIST_DEPTH+1)-1:0]     hist_count;
  logic                                parity_err;
  logic                                frame_err;
  logic                                busy;

  modport master (
    output ps2_clk, ps2_dat, clear_hist,
    input  code_valid, code, code_ext, code_break, history, hist_count,
           parity_err, frame_err, busy
  );

  modport slave (
    input  ps2_clk, ps2_dat, clear_hist,
    output code_valid, code, code_ext, code_break, history, hist_count,
           parity_err, frame_err, busy
  );
endinterface

// File: rtl/ps2_rx_history.sv
// PS/2 keyboard receiver: synchronised pins, 11-bit frame decode with parity,
// stop and timeout checks, E0/F0 prefix folding and a make-code history.
module ps2_rx_history #(
  parameter int HIST_DEPTH     = 3,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input logic              CLOCK_50,
  input logic              resetn,
  ps2_rx_history_if.slave  bus
);
  localparam int CW = $clog2(HIST_DEPTH+1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES-1);
  localparam logic [CW-1:0] CNT_MAX = CW'(HIST_DEPTH);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t                     state, next;
  logic [SYNC_STAGES-1:0]     clk_sync, dat_sync;
  logic                       prev_clk;
  logic                       sync_clk, sync_dat, fall;
  logic [2:0]                 bit_cnt;
  logic [7:0]                 shreg;
  logic                       par_bit;
  logic [TW-1:0]              tmo;
  logic                       ext_pend, brk_pend;
  logic [7:0]                 code_q;
  logic                       ext_q, brk_q, valid_q, perr_q, ferr_q;
  logic [HIST_DEPTH-1:0][7:0] hist;
  logic [CW-1:0]              cnt;
  logic                       perr, ferr, accept, is_prefix, push;

  assign sync_clk = clk_sync[SYNC_STAGES-1];
  assign sync_dat = dat_sync[SYNC_STAGES-1];
  assign fall     = prev_clk & ~sync_clk;

  // Idle bus is high, so the synchroniser resets to 1 to avoid a false fall.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      clk_sync <= '1;
      dat_sync <= '1;
      prev_clk <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], bus.ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], bus.ps2_dat};
      prev_clk <= sync_clk;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) state <= IDLE;
    else         state <= next;
  end

  always_comb begin
    next   = state;
    perr   = 1'b0;
    ferr   = 1'b0;
    accept = 1'b0;
    if (state != IDLE && !fall && tmo == TMO_MAX) begin
      next = IDLE;
      ferr = 1'b1;
    end else if (fall) begin
      case (state)
        IDLE:    if (!sync_dat) next = DATA;
        DATA:    if (bit_cnt == 3'd7) next = PARITY;
        PARITY:  next = STOP;
        STOP: begin
          next = IDLE;
          if (!sync_dat)                 ferr   = 1'b1;
          else if (par_bit != ~^shreg)   perr   = 1'b1;
          else                           accept = 1'b1;
        end
        default: next = IDLE;
      endcase
    end
  end

  assign is_prefix = (shreg == 8'hE0) || (shreg == 8'hF0);
  assign push      = accept && !is_prefix && !brk_pend;

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      tmo      <= '0;
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
      code_q   <= '0;
      ext_q    <= 1'b0;
      brk_q    <= 1'b0;
      valid_q  <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      hist     <= '0;
      cnt      <= '0;
    end else begin
      tmo     <= (fall || state == IDLE) ? '0 : tmo + 1'b1;
      valid_q <= 1'b0;
      perr_q  <= perr;
      ferr_q  <= ferr;

      if (fall && state == IDLE) bit_cnt <= '0;
      if (fall && state == DATA) begin
        shreg[bit_cnt] <= sync_dat;
        bit_cnt        <= bit_cnt + 3'd1;
      end
      if (fall && state == PARITY) par_bit <= sync_dat;

      if (perr || ferr) begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end else if (accept) begin
        if (shreg == 8'hE0)      ext_pend <= 1'b1;
        else if (shreg == 8'hF0) brk_pend <= 1'b1;
        else begin
          code_q   <= shreg;
          ext_q    <= ext_pend;
          brk_q    <= brk_pend;
          valid_q  <= 1'b1;
          ext_pend <= 1'b0;
          brk_pend <= 1'b0;
        end
      end

      // A push coinciding with clear leaves just the new code.
      if (bus.clear_hist) begin
        hist <= '0;
        cnt  <= '0;
        if (push) begin
          hist[0] <= shreg;
          cnt     <= CW'(1);
        end
      end else if (push) begin
        for (int i = HIST_DEPTH-1; i > 0; i--) hist[i] <= hist[i-1];
        hist[0] <= shreg;
        if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
      end
    end
  end

  assign bus.code_valid = valid_q;
  assign bus.code       = code_q;
  assign bus.code_ext   = ext_q;
  assign bus.code_break = brk_q;
  assign bus.history    = hist;
  assign bus.hist_count = cnt;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_ps2_rx_history.sv
// Bench for ps2_rx_history: frame vectors with expected events queued and
// matched against the pulses the receiver produces, plus timeout/reset cases.
module tb_ps2_rx_history;
  localparam int HD   = 3;
  localparam int SS   = 2;
  localparam int TO   = 200;
  localparam int HALF = 20;

  localparam logic [2:0] K_N = 3'b000;
  localparam logic [2:0] K_V = 3'b100;
  localparam logic [2:0] K_P = 3'b010;
  localparam logic [2:0] K_F = 3'b001;

  logic CLOCK_50 = 1'b0;
  logic resetn   = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  ps2_rx_history_if #(.HIST_DEPTH(HD)) dif();

  ps2_rx_history #(.HIST_DEPTH(HD), .SYNC_STAGES(SS), .TIMEOUT_CYCLES(TO)) dut (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .bus      (dif)
  );

  typedef struct {
    logic [2:0] kind;
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } ev_t;

  typedef struct {
    logic [7:0]  data;
    logic        bad_par;
    logic        stop;
    logic        clr;
    logic [2:0]  kind;
    logic [7:0]  code;
    logic        ext;
    logic        brk;
    logic [23:0] hist;
    int          cnt;
  } vec_t;

  ev_t  exp_q[$];
  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input logic [2:0] k, input logic [7:0] c, input logic e, input logic b);
    ev_t ev;
    ev.kind = k; ev.code = c; ev.ext = e; ev.brk = b;
    exp_q.push_back(ev);
  endtask

  always @(negedge CLOCK_50) begin : monitor
    ev_t got, want;
    if (resetn && (dif.code_valid || dif.parity_err || dif.frame_err)) begin
      got.kind = {dif.code_valid, dif.parity_err, dif.frame_err};
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pulse: got kind %b, expected none", got.kind);
      end else begin
        want = exp_q.pop_front();
        check("event_kind", {29'd0, got.kind}, {29'd0, want.kind});
        if (want.kind == K_V) begin
          check("event_code", {24'd0, dif.code}, {24'd0, want.code});
          check("event_ext",  {31'd0, dif.code_ext}, {31'd0, want.ext});
          check("event_brk",  {31'd0, dif.code_break}, {31'd0, want.brk});
        end
      end
    end
  end

  task automatic send_bit(input logic b, input logic clr);
    dif.ps2_dat = b;
    repeat (HALF) @(negedge CLOCK_50);
    dif.ps2_clk = 1'b0;
    if (clr) begin
      // Clear is held only up to the edge that registers the stop-bit fall.
      dif.clear_hist = 1'b1;
      repeat (SS+1) @(negedge CLOCK_50);
      dif.clear_hist = 1'b0;
      repeat (HALF-SS-1) @(negedge CLOCK_50);
    end else begin
      repeat (HALF) @(negedge CLOCK_50);
    end
    dif.ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop,
                            input logic clr);
    logic par;
    par = ~^d ^ bad_par;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i], 1'b0);
    send_bit(par, 1'b0);
    send_bit(stop, clr);
    dif.ps2_dat = 1'b1;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t v;
    dif.ps2_clk    = 1'b1;
    dif.ps2_dat    = 1'b1;
    dif.clear_hist = 1'b0;

    vecs.push_back('{8'h1C, 1'b0, 1'b1, 1'b0, K_V, 8'h1C, 1'b0, 1'b0, 24'h00001C, 1});
    vecs.push_back('{8'hF0, 1'b0, 1'b1, 1'b0, K_N, 8'h00, 1'b0, 1'b0, 24'h00001C, 1});
    vecs.push_back('{8'h1C, 1'b0, 1'b1, 1'b0, K_V, 8'h1C, 1'b0, 1'b1, 24'h00001C, 1});
    vecs.push_back('{8'hE0, 1'b0, 1'b1, 1'b0, K_N, 8'h00, 1'b0, 1'b0, 24'h00001C, 1});
    vecs.push_back('{8'h75, 1'b0, 1'b1, 1'b0, K_V, 8'h75, 1'b1, 1'b0, 24'h001C75, 2});
    vecs.push_back('{8'hF0, 1'b0, 1'b1, 1'b0, K_N, 8'h00, 1'b0, 1'b0, 24'h001C75, 2});
    vecs.push_back('{8'h1C, 1'b1, 1'b1, 1'b0, K_P, 8'h00, 1'b0, 1'b0, 24'h001C75, 2});
    vecs.push_back('{8'h1C, 1'b0, 1'b1, 1'b0, K_V, 8'h1C, 1'b0, 1'b0, 24'h1C751C, 3});
    vecs.push_back('{8'hE0, 1'b0, 1'b1, 1'b0, K_N, 8'h00, 1'b0, 1'b0, 24'h1C751C, 3});
    vecs.push_back('{8'h1C, 1'b0, 1'b0, 1'b0, K_F, 8'h00, 1'b0, 1'b0, 24'h1C751C, 3});
    vecs.push_back('{8'h32, 1'b0, 1'b1, 1'b0, K_V, 8'h32, 1'b0, 1'b0, 24'h751C32, 3});
    vecs.push_back('{8'h21, 1'b0, 1'b1, 1'b0, K_V, 8'h21, 1'b0, 1'b0, 24'h1C3221, 3});
    vecs.push_back('{8'h23, 1'b0, 1'b1, 1'b0, K_V, 8'h23, 1'b0, 1'b0, 24'h322123, 3});
    vecs.push_back('{8'h24, 1'b0, 1'b1, 1'b1, K_V, 8'h24, 1'b0, 1'b0, 24'h000024, 1});

    repeat (5) @(negedge CLOCK_50);
    resetn = 1'b1;
    @(negedge CLOCK_50);
    check("rst_code",  {24'd0, dif.code}, 32'd0);
    check("rst_flags", {29'd0, dif.code_ext, dif.code_break, dif.busy}, 32'd0);
    check("rst_pulses", {29'd0, dif.code_valid, dif.parity_err, dif.frame_err}, 32'd0);
    check("rst_history", {8'd0, dif.history}, 32'd0);
    check("rst_count", {30'd0, dif.hist_count}, 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      if (v.kind != K_N) expect_ev(v.kind, v.code, v.ext, v.brk);
      send_frame(v.data, v.bad_par, v.stop, v.clr);
      repeat (30) @(negedge CLOCK_50);
      check($sformatf("v%0d_pending", i), exp_q.size(), 32'd0);
      check($sformatf("v%0d_history", i), {8'd0, dif.history}, {8'd0, v.hist});
      check($sformatf("v%0d_count", i), {30'd0, dif.hist_count}, v.cnt);
      if (v.kind == K_V)
        check($sformatf("v%0d_code_held", i), {24'd0, dif.code}, {24'd0, v.code});
    end

    // Pending E0 then a truncated frame: timeout error must also drop the prefix.
    send_frame(8'hE0, 1'b0, 1'b1, 1'b0);
    repeat (10) @(negedge CLOCK_50);
    expect_ev(K_F, 8'h00, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0] ? 1'b1 : 1'b0, 1'b0);
    check("partial_busy", {31'd0, dif.busy}, 32'd1);
    repeat (TO + 50) @(negedge CLOCK_50);
    check("timeout_pending", exp_q.size(), 32'd0);
    check("timeout_busy", {31'd0, dif.busy}, 32'd0);
    expect_ev(K_V, 8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    repeat (30) @(negedge CLOCK_50);
    check("after_to_pending", exp_q.size(), 32'd0);
    check("after_to_history", {8'd0, dif.history}, 32'h0000241C);
    check("after_to_count", {30'd0, dif.hist_count}, 32'd2);

    // Busy timing on a start bit, then reset mid-frame.
    dif.ps2_dat = 1'b0;
    repeat (HALF) @(negedge CLOCK_50);
    dif.ps2_clk = 1'b0;
    repeat (SS) @(negedge CLOCK_50);
    check("busy_before_fall_reg", {31'd0, dif.busy}, 32'd0);
    @(negedge CLOCK_50);
    check("busy_after_start", {31'd0, dif.busy}, 32'd1);
    repeat (HALF-SS-1) @(negedge CLOCK_50);
    dif.ps2_clk = 1'b1;
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
    resetn = 1'b0;
    dif.ps2_dat = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    resetn = 1'b1;
    @(negedge CLOCK_50);
    check("midrst_code", {24'd0, dif.code}, 32'd0);
    check("midrst_flags", {29'd0, dif.code_ext, dif.code_break, dif.busy}, 32'd0);
    check("midrst_history", {8'd0, dif.history}, 32'd0);
    check("midrst_count", {30'd0, dif.hist_count}, 32'd0);
    repeat (20) @(negedge CLOCK_50);
    expect_ev(K_V, 8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    repeat (30) @(negedge CLOCK_50);
    check("post_rst_pending", exp_q.size(), 32'd0);
    check("post_rst_history", {8'd0, dif.history}, 32'h0000001C);
    check("post_rst_count", {30'd0, dif.hist_count}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
